adc_moving_avg: RTL and testbench
=================================

Name: adc_moving_avg

Overview:
- Upstream conditioning stage for the ADC→DAC amplifier path: takes raw 14-bit ADC samples, converts them to two's complement, and outputs a boxcar (moving) average over 2^LOG2_LEN samples.
- The averaged stream feeds the gain stage directly. Dropping noise before the x2 gain keeps that stage's saturation behaviour meaningful.
- Runs on the ADC clock domain only.

Parameters:
- DATA_W, 14: sample width, input and output.
- LOG2_LEN, 3: log2 of window length (window = 8). Legal range 1..5.
- OFFSET_BIN, 0: 1 = adc_in is offset binary, converted by inverting the MSB; 0 = adc_in is already two's complement.

Ports:
- clk  in  1  ADC sample clock.
- rst  in  1  synchronous, active-high reset.
- adc_in  in  DATA_W  raw ADC sample.
- in_valid  in  1  adc_in is a new sample this cycle.
- flush  in  1  one-cycle pulse; clears window history.
- adc_out  out  DATA_W  averaged sample, two's complement.
- out_valid  out  1  adc_out updated this cycle.
- primed  out  1  window has been filled with 2^LOG2_LEN real samples since the last reset or flush.

Behaviour:
- Reset (rst=1 at a clk edge):
  - adc_out=0, out_valid=0, primed=0.
  - Running sum=0, write pointer=0, fill counter=0.
  - All history registers = 0.
  - Any sample in flight is discarded.
- Stage 1 (edge N, in_valid=1):
  - s1_data <= converted adc_in; s1_valid <= 1.
  - Conversion: OFFSET_BIN=1 → {~adc_in[MSB], adc_in[MSB-1:0]}; otherwise pass-through.
- Stage 2 (edge N+1, s1_valid=1):
  - sum <= sum + s1_data − hist[wp]; hist[wp] <= s1_data; wp <= wp+1 (wraps modulo 2^LOG2_LEN).
  - adc_out <= (sum + s1_data − hist[wp]) >>> LOG2_LEN, i.e. the new sum arithmetically shifted (floor toward −inf).
  - out_valid <= 1.
- Latency and throughput:
  - out_valid is exactly in_valid delayed 2 clocks.
  - One sample per clock sustained.
  - No backpressure.
- Sum width is DATA_W+LOG2_LEN, signed, so the sum cannot overflow. Output always lies in [−2^(DATA_W−1), 2^(DATA_W−1)−1]; no saturation logic is needed.
- Fill (warm-up) behaviour:
  - History starts at zero, so the first 2^LOG2_LEN outputs ramp up from 0. This is intended.
  - Fill counter increments per stage-2 accept and saturates at 2^LOG2_LEN.
  - primed=1 from the edge where the counter reaches 2^LOG2_LEN.
- flush:
  - Same clearing effect as rst on sum, wp, history, fill counter and primed.
  - Also clears s1_valid; the sample in flight is dropped.
  - adc_out holds its last value and out_valid=0 in the next cycle.
  - flush and in_valid in the same cycle: flush wins and that sample is discarded.
- in_valid=0 cycles: no state change except out_valid dropping to 0. adc_out holds.
- rst mid-stream overrides everything; recovery timing is identical to power-up.

Decomposition:
- Shared package (adc_pkg): DATA_W=14 constant; function sum_width(L)=DATA_W+L; offset-binary conversion function, reused by other ADC-side blocks.
- Sub-module avg_ring_buf owns the history array, write pointer, fill counter and primed. Interface: push, clear, din, dout_oldest.
- Top level owns the conversion register, sum and output register.

Test Plan:
- Reset then 8 samples of 1000 (OFFSET_BIN=0) → outputs 125, 250, …, 1000; primed rises with the 8th output; out_valid 2 cycles after each in_valid.
- Primed window of 1000, then step input to −1000 → output falls by 250 per sample to −1000 after 8 samples. Inputs all −8192 → output −8192; all 8191 → output 8191 (extremes, no wrap).
- Floor check: window of seven 0s and one −1 → output −1; window of seven 0s and one +1 → output 0.
- OFFSET_BIN=1, 8 samples of 14'h2000 → output 0; 8 samples of 14'h3FFF → output 8191.
- Gapped in_valid (1 of every 3 cycles) → out_valid pattern identical, shifted 2 cycles; values match the ungapped run.
- flush asserted together with in_valid mid-window → that sample is dropped; primed=0; the next 8 samples of 800 give 100, 200, …, 800. rst asserted mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/adc_pkg.sv
// ============================================================================
// Module      : adc_pkg
// Description : Shared ADC-side constants and helpers (sample width, sum
//               sizing, offset-binary to two's complement conversion).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    localparam int ADC_DATA_W = 14;

    // Width of a running sum over 2^log2_len samples that can never overflow.
    function automatic int sum_width(input int log2_len);
        return ADC_DATA_W + log2_len;
    endfunction

    function automatic logic [ADC_DATA_W-1:0] offset_to_twos(input logic [ADC_DATA_W-1:0] raw);
        return {~raw[ADC_DATA_W-1], raw[ADC_DATA_W-2:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_moving_avg_if.sv
// ============================================================================
// Module      : adc_moving_avg_if
// Description : Sample-stream bundle between the ADC front end and the
//               moving-average stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_moving_avg_if #(
    parameter int DATA_W = 14
) ();

    logic [DATA_W-1:0] adc_in;
    logic              in_valid;
    logic              flush;
    logic [DATA_W-1:0] adc_out;
    logic              out_valid;
    logic              primed;

    modport master (
        output adc_in, in_valid, flush,
        input  adc_out, out_valid, primed
    );

    modport slave (
        input  adc_in, in_valid, flush,
        output adc_out, out_valid, primed
    );

endinterface

`default_nettype wire

// File: rtl/avg_ring_buf.sv
// ============================================================================
// Module      : avg_ring_buf
// Description : History ring for the boxcar average: oldest-sample readout,
//               wrapping write pointer and saturating fill counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avg_ring_buf #(
    parameter int DATA_W   = 14,
    parameter int LOG2_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_oldest,
    output logic              primed
);

    localparam int c_depth = 1 << LOG2_LEN;

    logic [DATA_W-1:0]   r_hist [c_depth];
    logic [LOG2_LEN-1:0] r_wp;
    logic [LOG2_LEN:0]   r_fill;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < c_depth; i++) begin
                r_hist[i] <= '0;
            end
            r_wp   <= '0;
            r_fill <= '0;
        end else if (push) begin
            r_hist[r_wp] <= din;
            r_wp         <= r_wp + 1'b1;
            // Saturates at exactly 2^LOG2_LEN, so the MSB alone means "full".
            if (!r_fill[LOG2_LEN]) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign dout_oldest = r_hist[r_wp];
    assign primed      = r_fill[LOG2_LEN];

endmodule

`default_nettype wire

// File: rtl/adc_moving_avg.sv
// ============================================================================
// Module      : adc_moving_avg
// Description : ADC sample conditioning: optional offset-binary conversion
//               followed by a 2^LOG2_LEN boxcar average, two-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_moving_avg
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_LEN   = 3,
    parameter bit OFFSET_BIN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    adc_moving_avg_if.slave   bus
);

    localparam int c_sum_w = sum_width(LOG2_LEN);

    logic [DATA_W-1:0]         w_conv;
    logic [DATA_W-1:0]         r_s1_data;
    logic                      r_s1_valid;
    logic [DATA_W-1:0]         w_oldest;
    logic                      w_push;
    logic                      w_primed;
    logic signed [c_sum_w-1:0] r_sum;
    logic signed [c_sum_w-1:0] w_new_ext;
    logic signed [c_sum_w-1:0] w_old_ext;
    logic signed [c_sum_w-1:0] w_sum_next;
    logic [DATA_W-1:0]         r_out;
    logic                      r_out_valid;

    generate
        if (OFFSET_BIN) begin : g_offset_bin
            assign w_conv = offset_to_twos(bus.adc_in);
        end else begin : g_twos
            assign w_conv = bus.adc_in;
        end
    endgenerate

    // A flush in the same cycle as a stage-2 accept drops that sample.
    assign w_push = r_s1_valid & ~bus.flush;

    avg_ring_buf #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .clear       (bus.flush),
        .din         (r_s1_data),
        .dout_oldest (w_oldest),
        .primed      (w_primed)
    );

    assign w_new_ext  = {{LOG2_LEN{r_s1_data[DATA_W-1]}}, r_s1_data};
    assign w_old_ext  = {{LOG2_LEN{w_oldest[DATA_W-1]}}, w_oldest};
    assign w_sum_next = r_sum + w_new_ext - w_old_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data   <= '0;
            r_s1_valid  <= 1'b0;
            r_sum       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_s1_valid  <= 1'b0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_s1_valid  <= bus.in_valid;
            r_out_valid <= r_s1_valid;
            if (bus.in_valid) begin
                r_s1_data <= w_conv;
            end
            if (r_s1_valid) begin
                r_sum <= w_sum_next;
                // Upper bits of the sum are the floor-shifted average.
                r_out <= w_sum_next[c_sum_w-1:LOG2_LEN];
            end
        end
    end

    assign bus.adc_out   = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.primed    = w_primed;

endmodule

`default_nettype wire

// File: tb/tb_adc_moving_avg.sv
// ============================================================================
// Module      : tb_adc_moving_avg
// Description : Directed self-checking bench for adc_moving_avg, one instance
//               per input coding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_moving_avg;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    adc_moving_avg_if #(.DATA_W(14)) bus0 ();
    adc_moving_avg_if #(.DATA_W(14)) bus1 ();

    adc_moving_avg #(.DATA_W(14), .LOG2_LEN(3), .OFFSET_BIN(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    adc_moving_avg #(.DATA_W(14), .LOG2_LEN(3), .OFFSET_BIN(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_vec = 0;
    int n_err = 0;
    int in_q[$];
    int exp_q[$];
    int prime_base;
    int last_exp[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_of(input bit sel);
        return sel ? int'($signed(bus1.adc_out)) : int'($signed(bus0.adc_out));
    endfunction

    function automatic int vld_of(input bit sel);
        return sel ? int'(bus1.out_valid) : int'(bus0.out_valid);
    endfunction

    function automatic int pri_of(input bit sel);
        return sel ? int'(bus1.primed) : int'(bus0.primed);
    endfunction

    task automatic drive(input bit sel, input bit v, input int d);
        logic [31:0] dv;
        dv = d;
        if (sel) begin
            bus1.in_valid = v;
            bus1.adc_in   = dv[13:0];
        end else begin
            bus0.in_valid = v;
            bus0.adc_in   = dv[13:0];
        end
    endtask

    task automatic load_const(input int v, input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back(v);
    endtask

    // Stream in_q with 'gap' idle cycles between samples; each output is
    // expected two edges after its in_valid, adc_out holding otherwise.
    task automatic run(input string tag, input bit sel, input int gap);
        int  n;
        int  total;
        int  k_in;
        int  k_out;
        bit  v;
        bit  vh[$];
        n     = in_q.size();
        total = n * (gap + 1) + 2;
        k_in  = 0;
        k_out = 0;
        for (int t = 0; t < total; t++) begin
            v = ((t % (gap + 1)) == 0) && (k_in < n);
            drive(sel, v, v ? in_q[k_in] : 0);
            if (v) k_in++;
            vh.push_back(v);
            tick();
            if (t >= 1) begin
                chk({tag, " out_valid"}, vld_of(sel), int'(vh[t-1]));
                if (vh[t-1]) begin
                    chk({tag, " adc_out"}, out_of(sel), exp_q[k_out]);
                    last_exp[sel] = exp_q[k_out];
                    if (prime_base >= 0)
                        chk({tag, " primed"}, pri_of(sel), int'(prime_base + k_out + 1 >= 8));
                    k_out++;
                end else begin
                    chk({tag, " hold"}, out_of(sel), last_exp[sel]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus0.adc_in = '0; bus0.in_valid = 1'b0; bus0.flush = 1'b0;
        bus1.adc_in = '0; bus1.in_valid = 1'b0; bus1.flush = 1'b0;
        last_exp[0] = 0;
        last_exp[1] = 0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset adc_out0", out_of(0), 0);
        chk("reset out_valid0", vld_of(0), 0);
        chk("reset primed0", pri_of(0), 0);
        chk("reset adc_out1", out_of(1), 0);
        chk("reset primed1", pri_of(1), 0);

        load_const(1000, 8);
        exp_q = '{125, 250, 375, 500, 625, 750, 875, 1000};
        prime_base = 0;
        run("ramp1000", 0, 0);

        load_const(-1000, 8);
        exp_q = '{750, 500, 250, 0, -250, -500, -750, -1000};
        prime_base = 8;
        run("step", 0, 0);

        load_const(-8192, 8);
        exp_q = '{-1899, -2798, -3697, -4596, -5495, -6394, -7293, -8192};
        run("negmax", 0, 0);

        load_const(8191, 8);
        exp_q = '{-6145, -4097, -2049, -1, 2047, 4095, 6143, 8191};
        run("posmax", 0, 0);

        load_const(0, 8);
        in_q.push_back(-1);
        for (int i = 0; i < 7; i++) in_q.push_back(0);
        in_q.push_back(1);
        exp_q = '{7167, 6143, 5119, 4095, 3071, 2047, 1023, 0,
                  -1, -1, -1, -1, -1, -1, -1, -1, 0};
        run("floor", 0, 0);

        load_const(14'h2000, 8);
        exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
        prime_base = 0;
        run("ob_mid", 1, 0);

        load_const(14'h3FFF, 8);
        exp_q = '{1023, 2047, 3071, 4095, 5119, 6143, 7167, 8191};
        prime_base = 8;
        run("ob_max", 1, 0);

        drive(0, 1, 800);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0);
        chk("midrst adc_out", out_of(0), 0);
        chk("midrst out_valid", vld_of(0), 0);
        chk("midrst primed", pri_of(0), 0);
        chk("midrst adc_out1", out_of(1), 0);
        last_exp[0] = 0;
        last_exp[1] = 0;
        tick();
        chk("midrst inflight", vld_of(0), 0);

        load_const(1000, 8);
        exp_q = '{125, 250, 375, 500, 625, 750, 875, 1000};
        prime_base = 0;
        run("gapped", 0, 2);

        drive(0, 1, 3000);
        tick();
        bus0.flush = 1'b1;
        drive(0, 1, 5000);
        tick();
        bus0.flush = 1'b0;
        drive(0, 0, 0);
        chk("flush out_valid", vld_of(0), 0);
        chk("flush hold", out_of(0), last_exp[0]);
        chk("flush primed", pri_of(0), 0);
        tick();
        chk("flush inflight", vld_of(0), 0);

        load_const(800, 8);
        exp_q = '{100, 200, 300, 400, 500, 600, 700, 800};
        prime_base = 0;
        run("post_flush", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
